// File: rtl/addsub_acc_seq_pkg.sv
// rtl/addsub_acc_seq_pkg.sv - shared state encoding, default widths and flag helper for addsub_acc_seq
package addsub_acc_seq_pkg;

  localparam int W_DEF     = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Signed overflow: operand signs agree (after k inverts y) but the sum sign differs.
  function automatic logic calc_ovf(input logic x_msb, input logic y_msb,
                                    input logic k, input logic s_msb);
    return ((x_msb ^ (y_msb ^ k)) == 1'b0) && (s_msb != x_msb);
  endfunction

endpackage

// File: rtl/FBAddSub.sv
// rtl/FBAddSub.sv - 4-bit ripple adder/subtractor with bit-level ports
module FBAddSub (
  input  logic x0,
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic y0,
  input  logic y1,
  input  logic y2,
  input  logic y3,
  input  logic k,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic cout
);

  // k inverts y and feeds the carry-in, giving x + ~y + 1 for subtraction.
  logic b0, b1, b2, b3;
  logic c1, c2, c3;

  assign b0 = y0 ^ k;
  assign b1 = y1 ^ k;
  assign b2 = y2 ^ k;
  assign b3 = y3 ^ k;

  assign s0   = x0 ^ b0 ^ k;
  assign c1   = (x0 & b0) | (k  & (x0 ^ b0));
  assign s1   = x1 ^ b1 ^ c1;
  assign c2   = (x1 & b1) | (c1 & (x1 ^ b1));
  assign s2   = x2 ^ b2 ^ c2;
  assign c3   = (x2 & b2) | (c2 & (x2 ^ b2));
  assign s3   = x3 ^ b3 ^ c3;
  assign cout = (x3 & b3) | (c3 & (x3 ^ b3));

endmodule

// File: rtl/addsub_acc_seq.sv
// rtl/addsub_acc_seq.sv - handshaked add/sub front end with result register, accumulator and op counter
module addsub_acc_seq
  import addsub_acc_seq_pkg::*;
#(
  parameter int W     = W_DEF,   // FBAddSub is fixed at 4 bits; only 4 is legal
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_k,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_s,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [W-1:0]     acc_q,
  output logic [CNT_W-1:0] op_count
);

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     x_q, x_d;
  logic [W-1:0]     y_q, y_d;
  logic             k_q, k_d;
  logic [W-1:0]     s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic [W-1:0]     acc_r_q, acc_r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [W-1:0]     fb_s;
  logic             fb_cout;

  // The adder sees only registered operands, so it settles during CALC.
  FBAddSub u_fbaddsub (
    .x0   (x_q[0]),
    .x1   (x_q[1]),
    .x2   (x_q[2]),
    .x3   (x_q[3]),
    .y0   (y_q[0]),
    .y1   (y_q[1]),
    .y2   (y_q[2]),
    .y3   (y_q[3]),
    .k    (k_q),
    .s0   (fb_s[0]),
    .s1   (fb_s[1]),
    .s2   (fb_s[2]),
    .s3   (fb_s[3]),
    .cout (fb_cout)
  );

  // Next-state, operand capture, result latch, accumulator and counter updates.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    x_d         = x_q;
    y_d         = y_q;
    k_d         = k_q;
    s_d         = s_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    acc_r_d     = acc_r_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_IDLE: begin
        // in_ready rises one edge after reset release, once IDLE is observed.
        in_ready_d = 1'b1;
        if (acc_clr) begin
          acc_r_d = '0;
        end
        if (in_valid && in_ready_q) begin
          // x is taken from the accumulator as it stands before any clear on this edge.
          x_d        = in_acc ? acc_r_q : in_a;
          y_d        = in_b;
          k_d        = in_k;
          state_d    = ST_CALC;
          in_ready_d = 1'b0;
        end
      end

      ST_CALC: begin
        s_d         = fb_s;
        cout_d      = fb_cout;
        ovf_d       = calc_ovf(x_q[W-1], y_q[W-1], k_q, fb_s[W-1]);
        zero_d      = ~|fb_s;
        out_valid_d = 1'b1;
        // A clear in CALC beats the result write-back; out_s still carries the result.
        acc_r_d     = acc_clr ? '0 : fb_s;
        in_ready_d  = 1'b0;
        state_d     = ST_HOLD;
      end

      ST_HOLD: begin
        if (acc_clr) begin
          acc_r_d = '0;
        end
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = cnt_q + CNT_W'(1);
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      k_q         <= 1'b0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      acc_r_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      k_q         <= k_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      acc_r_q     <= acc_r_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_s     = s_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;
  assign acc_q     = acc_r_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_addsub_acc_seq.sv
// tb/tb_addsub_acc_seq.sv - scoreboard bench for addsub_acc_seq with arithmetic reference model
module tb_addsub_acc_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       in_k;
  logic       in_acc;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_s;
  logic       out_cout;
  logic       out_ovf;
  logic       out_zero;
  logic [3:0] acc_q;
  logic [7:0] op_count;

  addsub_acc_seq #(.W(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_k      (in_k),
    .in_acc    (in_acc),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .acc_q     (acc_q),
    .op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int s;
    int cout;
    int ovf;
    int zero;
    int acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   model_acc = 0;
  int   model_cnt = 0;
  int   wrap_seen = 0;

  task automatic chk(input string nm, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic exp_t model(input int x, input int y, input int k);
    exp_t e;
    int   sx, sy, sr, raw;
    raw    = k ? (x - y) : (x + y);
    e.s    = raw & 15;
    e.cout = k ? int'(x >= y) : int'(x + y > 15);
    sx     = (x > 7) ? x - 16 : x;
    sy     = (y > 7) ? y - 16 : y;
    sr     = k ? (sx - sy) : (sx + sy);
    e.ovf  = int'((sr > 7) || (sr < -8));
    e.zero = int'(e.s == 0);
    e.acc  = e.s;
    return e;
  endfunction

  // Monitor: pops the expected result whenever a transfer is about to complete.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 0, 1);
        end else begin
          e = exp_q.pop_front();
          chk("out_s",    int'(out_s),    e.s);
          chk("out_cout", int'(out_cout), e.cout);
          chk("out_ovf",  int'(out_ovf),  e.ovf);
          chk("out_zero", int'(out_zero), e.zero);
          chk("acc_q",    int'(acc_q),    e.acc);
          model_cnt = (model_cnt + 1) % 256;
          if (model_cnt == 0) wrap_seen = 1;
          @(negedge clk);
          chk("op_count",        int'(op_count),  model_cnt);
          chk("valid_after_xfer", int'(out_valid), 0);
        end
      end
    end
  end

  // One request through accept, CALC, optional backpressure and transfer.
  task automatic do_op(input int a, input int b, input int k, input int acc,
                       input int clr_calc, input int hold);
    exp_t e;
    int   n;
    in_a     = 4'(a);
    in_b     = 4'(b);
    in_k     = k[0];
    in_acc   = acc[0];
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    e = model(acc ? model_acc : a, b, k);
    if (clr_calc != 0) e.acc = 0;
    model_acc = e.acc;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = 4'($urandom);
    chk("calc_no_valid", int'(out_valid), 0);
    chk("calc_busy",     int'(in_ready),  0);
    if (clr_calc != 0) acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    chk("latency_valid", int'(out_valid), 1);
    if (hold > 0) begin
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'($urandom_range(0, 1));
        in_b     = 4'($urandom);
        @(posedge clk); #1;
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_s",     int'(out_s),     e.s);
        chk("hold_ovf",   int'(out_ovf),   e.ovf);
        chk("hold_busy",  int'(in_ready),  0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("ready_after_xfer", int'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_k      = 1'b0;
    in_acc    = 1'b0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;

    // Reset asserted mid-CALC discards the op.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    in_a = 4'd3; in_b = 4'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_calc", int'(out_valid), 0);
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready",  int'(in_ready),  0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_s",     int'(out_s),     0);
    chk("rst_flags",     int'({out_cout, out_ovf, out_zero}), 0);
    chk("rst_acc",       int'(acc_q),     0);
    chk("rst_op_count",  int'(op_count),  0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("release_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    chk("idle_in_ready",   int'(in_ready),  1);
    chk("idle_op_count",   int'(op_count),  0);
    chk("idle_out_valid",  int'(out_valid), 0);
    repeat (2) @(negedge clk);
    chk("no_partial_output", int'(out_valid), 0);
    @(posedge clk); #1;

    // Directed arithmetic cases.
    do_op(7, 12, 0, 0, 0, 0);
    do_op(13, 2, 1, 0, 0, 0);
    do_op(2, 6, 1, 0, 0, 0);
    do_op(7, 1, 0, 0, 0, 0);
    do_op(8, 1, 1, 0, 0, 0);
    do_op(4, 4, 1, 0, 0, 0);

    // Accumulate chain, then clear during CALC of the next op.
    do_op(5, 0, 0, 0, 0, 0);
    chk("acc_chain_1", int'(acc_q), 5);
    do_op(0, 3, 0, 1, 0, 0);
    chk("acc_chain_2", int'(acc_q), 8);
    do_op(0, 9, 1, 1, 0, 0);
    chk("acc_chain_3", int'(acc_q), 15);
    do_op(0, 2, 0, 1, 1, 0);
    chk("acc_clr_calc", int'(acc_q), 0);

    // Clear while idle.
    do_op(6, 0, 0, 0, 0, 0);
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    model_acc = 0;
    chk("acc_clr_idle", int'(acc_q), 0);

    // Backpressure for 5 cycles with ignored requests.
    do_op(9, 3, 0, 0, 0, 5);

    // Randomized traffic, long enough to wrap the 8-bit counter.
    for (int i = 0; i < 260; i++) begin
      do_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1),
            $urandom_range(0, 1), int'($urandom_range(0, 7) == 0), $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("op_count_wrapped", wrap_seen, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
